inst_fetch_queue: RTL and testbench

Front-end fetch unit that drives the instruction-memory read port and buffers returned instructions for the decode stage. It sits directly upstream of decode: it issues sequential reads with a fixed-latency memory model, tags in-flight reads so they can be squashed, and presents one instruction per cycle to decode over a valid/ready handshake. It accepts redirects from execute (taken JMP/JEQ, mispredict correction) and stops fetching once a HLT has been enqueued.

---
 rtl/inst_fetch_queue_pkg.sv | 33 +++
 rtl/inst_fetch_queue_fifo.sv | 56 +++++
 rtl/inst_fetch_queue.sv | 137 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-queue types: opcodes, widths and FIFO entry layout.
// Imported by the fetch queue top and its FIFO.
package inst_fetch_queue_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_JMP = 4'd2,
        OP_HLT = 4'd3,
        OP_LD  = 4'd4,
        OP_LDR = 4'd5,
        OP_JEQ = 4'd6,
        OP_ST  = 4'd7
    } opcode_e;

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: 4] == OP_HLT;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous {pc,inst} FIFO between the memory return and decode.
// Flush empties it in one cycle; count is exposed for credit checks.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fq_entry_t                  i_data,
    input  logic                       i_pop,
    output fq_entry_t                  o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    fq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;

    // Storage, pointers and occupancy; flush restarts both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PTR_ONE;
            end
            if (i_pop) r_rd <= r_rd + PTR_ONE;
            if (i_push && !i_pop)      r_cnt <= r_cnt + CNT_ONE;
            else if (!i_push && i_pop) r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && (r_cnt == CW'(DEPTH))));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues sequential reads, tags them with an epoch,
// buffers returns and hands one instruction per cycle to decode.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_ren,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        d_valid,
    output logic [15:0] d_inst,
    output logic [15:0] d_pc,
    input  logic        d_ready,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e          r_state;
    fq_state_e          w_state_nxt;
    logic [15:0]        r_fetch_pc;
    logic               r_epoch;
    logic [MEM_LAT-1:0] r_pv;
    logic [MEM_LAT-1:0] r_pe;
    logic [15:0]        r_ppc [MEM_LAT];

    logic [CW-1:0]      w_count;
    fq_entry_t          w_head;
    fq_entry_t          w_ret;
    logic [15:0]        w_inflight;
    logic               w_credit;
    logic               w_issue;
    logic               w_ret_ok;
    logic               w_enq;
    logic               w_hlt;
    logic               w_dvalid;
    logic               w_pop;
    logic               w_epoch_flip;

    // Live in-flight reads (stale-epoch ones no longer hold a slot).
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (r_pv[i] && (r_pe[i] == r_epoch)) begin
                w_inflight = w_inflight + 16'd1;
            end
        end
        w_credit = (16'(w_count) + w_inflight) < 16'(DEPTH);
    end

    assign w_ret_ok = r_pv[MEM_LAT-1] && (r_pe[MEM_LAT-1] == r_epoch);
    assign w_enq    = w_ret_ok && !redirect_valid;
    assign w_hlt    = w_enq && is_hlt(mem_rdata);
    assign w_dvalid = (w_count != '0) && !redirect_valid;
    assign w_pop    = w_dvalid && d_ready;
    assign w_ret    = '{pc: r_ppc[MEM_LAT-1], inst: mem_rdata};

    // Next state and issue decision; redirect overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_epoch_flip = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_issue = w_credit && !redirect_valid && rst_n;
                if (w_hlt) begin
                    w_state_nxt  = S_HALTED;
                    w_epoch_flip = 1'b1;
                end
            end
            S_HALTED: begin
                w_issue = 1'b0;
            end
        endcase
        if (redirect_valid) begin
            w_state_nxt  = S_FETCH;
            w_epoch_flip = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    // Fetch PC, epoch and the MEM_LAT-deep in-flight tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_epoch    <= 1'b0;
            r_pv       <= '0;
            r_pe       <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_ppc[i] <= '0;
        end else begin
            if (w_epoch_flip) r_epoch <= ~r_epoch;
            if (redirect_valid) r_fetch_pc <= redirect_pc;
            else if (w_issue)   r_fetch_pc <= r_fetch_pc + 16'd1;
            r_pv[0]  <= w_issue;
            r_pe[0]  <= r_epoch;
            r_ppc[0] <= r_fetch_pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pe[i]  <= r_pe[i-1];
                r_ppc[i] <= r_ppc[i-1];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_enq),
        .i_data  (w_ret),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign mem_ren   = w_issue;
    assign mem_raddr = r_fetch_pc;
    assign d_valid   = w_dvalid;
    assign d_inst    = w_head.inst;
    assign d_pc      = w_head.pc;
    assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: cycle vector table, directed corner
// sequences and a randomized run against a stream scoreboard.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        d_valid;
    logic [15:0] d_inst;
    logic [15:0] d_pc;
    logic        d_ready = 1'b0;
    logic        halted;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .MEM_LAT  (LAT),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_valid        (d_valid),
        .d_inst         (d_inst),
        .d_pc           (d_pc),
        .d_ready        (d_ready),
        .halted         (halted)
    );

    // memory image: 0 plain, 1 single HLT at hlt_addr, 2 HLT every 32
    int          mode = 0;
    logic [15:0] hlt_addr = 16'h0005;

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [11:0] lo;
        lo = a[11:0] * 12'h111 + 12'h012;
        if (mode == 1 && a == hlt_addr) return 16'h3000;
        if (mode == 2 && a[4:0] == 5'h1B) return {4'h3, lo};
        return {4'h1, lo};
    endfunction

    // fixed-latency memory: address history, data driven mid-cycle
    logic [15:0] h_addr [1:LAT];
    initial for (int k = 1; k <= LAT; k++) h_addr[k] = 16'h0;
    always @(posedge clk) begin
        for (int k = LAT; k > 1; k--) h_addr[k] <= h_addr[k-1];
        h_addr[1] <= mem_raddr;
    end
    always @(negedge clk) mem_rdata = memf(h_addr[LAT]);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".ren"},   32'(mem_ren), 0);
        chk({tag, ".addr"},  32'(mem_raddr), 0);
        chk({tag, ".dv"},    32'(d_valid), 0);
        chk({tag, ".dinst"}, 32'(d_inst), 0);
        chk({tag, ".dpc"},   32'(d_pc), 0);
        chk({tag, ".halt"},  32'(halted), 0);
    endtask

    // leaves the bench at the negedge opening cycle 0
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        d_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        ren;
        logic [15:0] addr;
        logic        dv;
        logic [15:0] dpc;
    } vec_t;

    vec_t tv [28];

    function automatic vec_t mk(logic rdy, logic rv, logic [15:0] rpc,
                                logic ren, logic [15:0] addr,
                                logic dv, logic [15:0] dpc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ren = ren;
        v.addr = addr; v.dv = dv; v.dpc = dpc;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got_pc [4];
        logic [15:0] got_in [4];
        int          got;
        int          first_c;
        logic [15:0] first_pc;
        logic [15:0] exp_pc;
        logic        stopped;
        logic        prev_rv;
        int          stall;
        logic        xfer;

        // steady fetch, 10-cycle stall, refill, redirect to 0x0040
        for (int i = 0; i < 6; i++)
            tv[i] = mk(1, 0, 0, 1, 16'(i), i >= 3, 16'(i - 3));
        tv[6] = mk(0, 0, 0, 1, 16'd6, 1, 16'd3);
        for (int i = 7; i < 16; i++)
            tv[i] = mk(0, 0, 0, 0, 16'd7, 1, 16'd3);
        tv[16] = mk(1, 0, 0, 0, 16'd7, 1, 16'd3);
        for (int i = 17; i < 22; i++)
            tv[i] = mk(1, 0, 0, 1, 16'(i - 10), 1, 16'(i - 13));
        tv[22] = mk(1, 1, 16'h0040, 0, 16'd12, 0, 0);
        for (int i = 23; i < 28; i++)
            tv[i] = mk(1, 0, 0, 1, 16'(16'h0040 + i - 23),
                       i >= 26, 16'(16'h0040 + i - 26));

        // ---- reset state
        mode = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs("rst");
        rst_n = 1'b1;

        // ---- table
        for (int i = 0; i < 28; i++) begin
            d_ready = tv[i].rdy;
            redirect_valid = tv[i].rv;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("v%0d.ren", i), 32'(mem_ren), 32'(tv[i].ren));
            chk($sformatf("v%0d.addr", i), 32'(mem_raddr), 32'(tv[i].addr));
            chk($sformatf("v%0d.dv", i), 32'(d_valid), 32'(tv[i].dv));
            if (tv[i].dv) begin
                chk($sformatf("v%0d.dpc", i), 32'(d_pc), 32'(tv[i].dpc));
                chk($sformatf("v%0d.dinst", i), 32'(d_inst),
                    32'(memf(tv[i].dpc)));
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        // ---- HLT at 5, then redirect to 0x0010
        mode = 1;
        hlt_addr = 16'h0005;
        do_reset();
        d_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c == 7) chk("hlt.pre", 32'(halted), 0);
            if (c == 8) begin
                chk("hlt.halt", 32'(halted), 1);
                chk("hlt.ren", 32'(mem_ren), 0);
                chk("hlt.dv", 32'(d_valid), 1);
                chk("hlt.dpc", 32'(d_pc), 5);
                chk("hlt.dinst", 32'(d_inst), 32'h3000);
            end
            if (c > 8) chk($sformatf("hlt.quiet%0d", c),
                           {30'd0, d_valid, mem_ren}, 0);
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        #1;
        chk("hlt.rvhalt", 32'(halted), 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("hlt.clr", 32'(halted), 0);
        chk("hlt.ren2", 32'(mem_ren), 1);
        chk("hlt.addr2", 32'(mem_raddr), 32'h0010);
        repeat (3) @(negedge clk);
        #1;
        chk("hlt.dv2", 32'(d_valid), 1);
        chk("hlt.dpc2", 32'(d_pc), 32'h0010);

        // ---- HLT enqueue and redirect in the same cycle
        do_reset();
        d_ready = 1'b1;
        repeat (7) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        #1;
        chk("hr.dv", 32'(d_valid), 0);
        chk("hr.ren", 32'(mem_ren), 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("hr.halt", 32'(halted), 0);
        chk("hr.ren2", 32'(mem_ren), 1);
        chk("hr.addr", 32'(mem_raddr), 32'h0020);
        repeat (3) @(negedge clk);
        #1;
        chk("hr.dpc", {15'd0, d_valid, d_pc}, {15'd0, 1'b1, 16'h0020});

        // ---- PC wrap
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (d_valid && got < 4) begin
                got_pc[got] = d_pc;
                got_in[got] = d_inst;
                got++;
            end
            @(negedge clk);
        end
        chk("wrap.cnt", 32'(got), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got) begin
                chk($sformatf("wrap.pc%0d", k), 32'(got_pc[k]),
                    32'(16'(16'hFFFE + k)));
                chk($sformatf("wrap.in%0d", k), 32'(got_in[k]),
                    32'(memf(16'(16'hFFFE + k))));
            end
        end

        // ---- reset pulse with queue filling and reads in flight
        d_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d_ready = 1'b1;
        first_c = -1;
        first_pc = 16'hDEAD;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (d_valid && first_c < 0) begin
                first_c = c;
                first_pc = d_pc;
                chk("mrst.inst", 32'(d_inst), 32'(memf(16'h0000)));
            end
            @(negedge clk);
        end
        chk("mrst.lat", first_c, 3);
        chk("mrst.pc", 32'(first_pc), 0);

        // ---- randomized run against stream scoreboard
        mode = 2;
        do_reset();
        exp_pc = 16'h0000;
        stopped = 1'b0;
        prev_rv = 1'b0;
        stall = 0;
        for (int n = 0; n < 3000; n++) begin
            d_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0)
                        ? 16'(16'hFFFC + $urandom_range(0, 3))
                        : 16'($urandom_range(0, 65535));
            #1;
            if (prev_rv) chk("rnd.hclr", 32'(halted), 0);
            if (redirect_valid)
                chk("rnd.rvq", {30'd0, d_valid, mem_ren}, 0);
            if (stopped)
                chk("rnd.stop", {29'd0, halted, d_valid, mem_ren}, 32'd4);
            xfer = d_valid && d_ready;
            if (xfer) begin
                chk("rnd.pc", 32'(d_pc), 32'(exp_pc));
                chk("rnd.inst", 32'(d_inst), 32'(memf(exp_pc)));
                if (memf(exp_pc) >> 12 == 16'd3) begin
                    chk("rnd.hlt", 32'(halted), 1);
                    stopped = 1'b1;
                end
                exp_pc = exp_pc + 16'd1;
                stall = 0;
            end else if (d_ready && !redirect_valid && !stopped) begin
                stall++;
            end
            if (redirect_valid || stopped) stall = 0;
            chk("rnd.live", 32'(stall <= 8), 1);
            prev_rv = redirect_valid;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                stopped = 1'b0;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
